// File: rtl/act_pkg.sv
// act_pkg: shared state encoding and sizing constants for the activation stage
package act_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
    localparam int ACC_W        = 32;
    localparam int OUT_W        = 8;
    localparam int ELEMS_PER_RD = 4;
    localparam int BYTES_PER_WR = 16;
endpackage

// File: rtl/act_relu_sat.sv
// act_relu_sat: one ReLU, arithmetic shift and int8 saturation lane; ACT_ROUND_EN adds round-half-up
module act_relu_sat
    import act_pkg::*;
(
    input  logic signed [ACC_W-1:0] x,
    input  logic [4:0]              shift,
    output logic [OUT_W-1:0]        y
);
    logic [ACC_W:0] xe;
    logic [ACC_W:0] s;
`ifdef ACT_ROUND_EN
    assign xe = {1'b0, x} + ((shift == 5'd0) ? '0 : (ACC_W+1)'(1) << (shift - 5'd1));
`else
    assign xe = {1'b0, x};
`endif
    assign s = xe >> shift;
    assign y = x[ACC_W-1] ? '0 : (s > (ACC_W+1)'(127)) ? OUT_W'(127) : s[OUT_W-1:0];
endmodule

// File: rtl/act_relu_quant.sv
// act_relu_quant: streams int32 accumulators through ReLU/shift/int8 saturation into packed bytes (ACT_ROUND_EN: rounding)
module act_relu_quant
    import act_pkg::*;
#(
    parameter int ADDR_WIDTH   = 19,
    parameter int MEM_DATA_BUS = 128,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sw_act_start,
    input  logic [ADDR_WIDTH-1:0]   sw_act_rd_addr,
    input  logic [ADDR_WIDTH-1:0]   sw_act_wr_addr,
    input  logic [LEN_WIDTH-1:0]    sw_act_len,
    input  logic [4:0]              sw_act_shift,
    output logic                    act_sw_busy_ind,
    output logic                    act_sw_done,
    output logic                    mem_rd_req,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic                    mem_rd_gnt,
    input  logic                    mem_rd_valid,
    input  logic [MEM_DATA_BUS-1:0] mem_rd_data,
    output logic                    mem_wr_req,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [MEM_DATA_BUS-1:0] mem_wr_data,
    output logic [15:0]             mem_wr_be,
    input  logic                    mem_wr_gnt
);
    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   rd_addr, wr_addr;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [4:0]              shift_q;
    logic [LEN_WIDTH:0]      idx, idx_nx;
    logic [MEM_DATA_BUS-1:0] data_q;
    logic [15:0]             be_q;
    logic [ELEMS_PER_RD-1:0] lane_ok;
    logic [OUT_W-1:0]        y [ELEMS_PER_RD];
    logic                    last;
    for (genvar g = 0; g < ELEMS_PER_RD; g++) begin : g_lane
        act_relu_sat u_lane (
            .x     (mem_rd_data[ACC_W*g +: ACC_W]),
            .shift (shift_q),
            .y     (y[g])
        );
        assign lane_ok[g] = (idx + (LEN_WIDTH+1)'(g)) < {1'b0, len_q};
    end
    assign idx_nx          = idx + (LEN_WIDTH+1)'(ELEMS_PER_RD);
    assign last            = idx_nx >= {1'b0, len_q};
    assign act_sw_busy_ind = state != IDLE;
    assign act_sw_done     = state == DONE;
    assign mem_rd_req      = state == RD_REQ;
    assign mem_wr_req      = state == WR_REQ;
    assign mem_rd_addr     = rd_addr;
    assign mem_wr_addr     = wr_addr;
    assign mem_wr_data     = data_q;
    assign mem_wr_be       = be_q;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sw_act_start) state_nx = (sw_act_len == '0) ? DONE : RD_REQ;
            RD_REQ:  if (mem_rd_gnt) state_nx = RD_WAIT;
            RD_WAIT: if (mem_rd_valid) state_nx = (last || idx_nx[3:0] == 4'd0) ? WR_REQ : RD_REQ;
            WR_REQ:  if (mem_wr_gnt) state_nx = (idx < {1'b0, len_q}) ? RD_REQ : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Slot buffer is cleared after every write so tail bytes go out as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
            wr_addr <= '0;
            len_q   <= '0;
            shift_q <= '0;
            idx     <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            if (state == IDLE && sw_act_start) begin
                rd_addr <= sw_act_rd_addr;
                wr_addr <= sw_act_wr_addr;
                len_q   <= sw_act_len;
                shift_q <= sw_act_shift;
                idx     <= '0;
                data_q  <= '0;
                be_q    <= '0;
            end
            if (state == RD_REQ && mem_rd_gnt) rd_addr <= rd_addr + ADDR_WIDTH'(16);
            if (state == RD_WAIT && mem_rd_valid) begin
                for (int j = 0; j < ELEMS_PER_RD; j++)
                    if (lane_ok[j]) begin
                        data_q[{idx[3:2], 2'(j), 3'b000} +: OUT_W] <= y[j];
                        be_q[{idx[3:2], 2'(j)}] <= 1'b1;
                    end
                idx <= idx_nx;
            end
            if (state == WR_REQ && mem_wr_gnt) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(16);
                data_q  <= '0;
                be_q    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_act_relu_quant.sv
// tb_act_relu_quant: memory responder with write scoreboard, lane vector table and job-level corner sequences
module tb_act_relu_quant;
    logic         clk = 0;
    logic         rst_n;
    logic         sw_act_start;
    logic [18:0]  sw_act_rd_addr, sw_act_wr_addr;
    logic [15:0]  sw_act_len;
    logic [4:0]   sw_act_shift;
    logic         act_sw_busy_ind, act_sw_done;
    logic         mem_rd_req, mem_rd_gnt, mem_rd_valid;
    logic [18:0]  mem_rd_addr, mem_wr_addr;
    logic [127:0] mem_rd_data, mem_wr_data;
    logic         mem_wr_req, mem_wr_gnt;
    logic [15:0]  mem_wr_be;

    act_relu_quant dut (
        .clk(clk), .rst_n(rst_n), .sw_act_start(sw_act_start),
        .sw_act_rd_addr(sw_act_rd_addr), .sw_act_wr_addr(sw_act_wr_addr),
        .sw_act_len(sw_act_len), .sw_act_shift(sw_act_shift),
        .act_sw_busy_ind(act_sw_busy_ind), .act_sw_done(act_sw_done),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_gnt(mem_wr_gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0]  addr;
        logic [127:0] data;
        logic [15:0]  be;
    } wr_t;

    typedef struct {
        int          acc;
        logic [4:0]  sh;
        logic [7:0]  y_trunc;
        logic [7:0]  y_round;
    } vec_t;

    wr_t   wq[$];
    int    acc_mem [int];
    int    n_chk = 0, n_fail = 0;
    int    n_rd = 0, n_wr = 0;
    int    rd_delay = 0, wr_delay = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input int x, input int sh);
        longint v;
        if (x < 0) return 8'd0;
        v = longint'(x);
`ifdef ACT_ROUND_EN
        if (sh > 0) v += longint'(1) << (sh - 1);
`endif
        v = v >> sh;
        return (v > 127) ? 8'd127 : v[7:0];
    endfunction

    function automatic logic [127:0] rd_word(input logic [18:0] a);
        logic [127:0] w;
        int k;
        for (int j = 0; j < 4; j++) begin
            k = int'(a >> 2) + j;
            w[32*j +: 32] = acc_mem.exists(k) ? acc_mem[k] : 32'h55;
        end
        return w;
    endfunction

    // Memory responder: grants after rd_delay/wr_delay held cycles, read data one cycle after grant.
    logic         rd_pend = 0;
    logic [18:0]  rd_pend_addr;
    int           rd_cnt = 0, wr_cnt = 0;
    logic         p_rd_hold = 0, p_wr_hold = 0;
    logic [18:0]  p_rd_addr, p_wr_addr;
    logic [127:0] p_wr_data;
    logic [15:0]  p_wr_be;
    initial begin
        wr_t e;
        mem_rd_gnt = 0; mem_wr_gnt = 0; mem_rd_valid = 0; mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (p_rd_hold && rst_n) begin
                check("rd_hold_req", mem_rd_req, 1);
                check("rd_hold_addr", mem_rd_addr, p_rd_addr);
            end
            if (p_wr_hold && rst_n) begin
                check("wr_hold_req", mem_wr_req, 1);
                check("wr_hold_addr", mem_wr_addr, p_wr_addr);
                check("wr_hold_data", mem_wr_data, p_wr_data);
                check("wr_hold_be", mem_wr_be, p_wr_be);
            end
            mem_rd_valid = 0;
            if (rd_pend) begin
                mem_rd_valid = 1;
                mem_rd_data = rd_word(rd_pend_addr);
                rd_pend = 0;
            end
            if (mem_rd_gnt) mem_rd_gnt = 0;
            else if (mem_rd_req && rst_n) begin
                if (rd_cnt < rd_delay) rd_cnt++;
                else begin
                    mem_rd_gnt = 1; rd_cnt = 0; rd_pend = 1; rd_pend_addr = mem_rd_addr; n_rd++;
                end
            end
            if (mem_wr_gnt) mem_wr_gnt = 0;
            else if (mem_wr_req && rst_n) begin
                if (wr_cnt < wr_delay) wr_cnt++;
                else begin
                    mem_wr_gnt = 1; wr_cnt = 0; n_wr++;
                    if (wq.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        e = wq.pop_front();
                        check("wr_addr", mem_wr_addr, e.addr);
                        check("wr_data", mem_wr_data, e.data);
                        check("wr_be", mem_wr_be, e.be);
                    end
                end
            end
            if (!rst_n) begin rd_cnt = 0; wr_cnt = 0; end
            p_rd_hold = mem_rd_req && !mem_rd_gnt && rst_n;
            p_rd_addr = mem_rd_addr;
            p_wr_hold = mem_wr_req && !mem_wr_gnt && rst_n;
            p_wr_addr = mem_wr_addr;
            p_wr_data = mem_wr_data;
            p_wr_be   = mem_wr_be;
        end
    end

    task automatic push_model(input logic [18:0] ra, input logic [18:0] wa, input int len, input int sh);
        wr_t e;
        int el;
        for (int w = 0; w < (len + 15) / 16; w++) begin
            e.addr = wa + 19'(16 * w); e.data = '0; e.be = '0;
            for (int b = 0; b < 16; b++) begin
                el = w * 16 + b;
                if (el < len) begin
                    e.data[8*b +: 8] = ref_q(acc_mem[int'(ra >> 2) + el], sh);
                    e.be[b] = 1'b1;
                end
            end
            wq.push_back(e);
        end
    endtask

    task automatic job(input logic [18:0] ra, input logic [18:0] wa, input int len, input logic [4:0] sh, input bit model);
        int cyc;
        logic seen;
        if (model) push_model(ra, wa, len, int'(sh));
        @(negedge clk);
        n_rd = 0; n_wr = 0;
        sw_act_rd_addr = ra; sw_act_wr_addr = wa; sw_act_len = 16'(len); sw_act_shift = sh;
        sw_act_start = 1;
        @(negedge clk);
        sw_act_start = 0;
        check("busy_after_start", act_sw_busy_ind, 1);
        cyc = 1;
        seen = act_sw_done;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            seen = act_sw_done;
        end
        check("done_pulse", seen, 1);
        @(negedge clk);
        check("done_one_cycle", act_sw_done, 0);
        check("busy_drop", act_sw_busy_ind, 0);
        check("rd_count", n_rd, (len + 3) / 4);
        check("wr_count", n_wr, (len + 15) / 16);
        check("sb_empty", wq.size(), 0);
        if (len == 0) check("len0_busy_cycles", cyc, 1);
    endtask

    vec_t vt [12];
    wr_t  e;
    int   vals6 [6] = '{-5, 300, 127, 128, -1, 64};
    int   cyc;
    logic bad;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{40, 5'd4, 8'd2, 8'd3};
        vt[1]  = '{32'h7FFFFFFF, 5'd31, 8'd0, 8'd1};
        vt[2]  = '{-5, 5'd0, 8'd0, 8'd0};
        vt[3]  = '{300, 5'd0, 8'd127, 8'd127};
        vt[4]  = '{127, 5'd0, 8'd127, 8'd127};
        vt[5]  = '{128, 5'd0, 8'd127, 8'd127};
        vt[6]  = '{32'h80000000, 5'd0, 8'd0, 8'd0};
        vt[7]  = '{2040, 5'd4, 8'd127, 8'd127};
        vt[8]  = '{24, 5'd4, 8'd1, 8'd2};
        vt[9]  = '{2032, 5'd4, 8'd127, 8'd127};
        vt[10] = '{7, 5'd1, 8'd3, 8'd4};
        vt[11] = '{1, 5'd0, 8'd1, 8'd1};

        rst_n = 0; sw_act_start = 0; sw_act_rd_addr = '0; sw_act_wr_addr = '0; sw_act_len = '0; sw_act_shift = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", act_sw_busy_ind, 0);
        check("rst_done", act_sw_done, 0);
        check("rst_rd_req", mem_rd_req, 0);
        check("rst_wr_req", mem_wr_req, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_wr_be", mem_wr_be, 0);
        rst_n = 1;

        acc_mem.delete();
        for (int i = 0; i < 16; i++) acc_mem[(32'h100 >> 2) + i] = i;
        e.addr = 19'h4000; e.be = 16'hFFFF;
        for (int i = 0; i < 16; i++) e.data[8*i +: 8] = 8'(i);
        wq.push_back(e);
        job(19'h100, 19'h4000, 16, 5'd0, 0);

        acc_mem.delete();
        for (int i = 0; i < 6; i++) acc_mem[(32'h200 >> 2) + i] = vals6[i];
        e.addr = 19'h4100; e.be = 16'h003F;
        e.data = {80'h0, 8'd64, 8'd0, 8'd127, 8'd127, 8'd127, 8'd0};
        wq.push_back(e);
        job(19'h200, 19'h4100, 6, 5'd0, 0);

        for (int i = 0; i < 12; i++) begin
            acc_mem.delete();
            acc_mem[(32'h2000 + i * 16) >> 2] = vt[i].acc;
            e.addr = 19'h5000 + 19'(i * 16); e.be = 16'h0001;
`ifdef ACT_ROUND_EN
            e.data = {120'h0, vt[i].y_round};
`else
            e.data = {120'h0, vt[i].y_trunc};
`endif
            wq.push_back(e);
            job(19'h2000 + 19'(i * 16), 19'h5000 + 19'(i * 16), 1, vt[i].sh, 0);
        end

        acc_mem.delete();
        for (int i = 0; i < 16; i++) acc_mem[(32'h3000 >> 2) + i] = int'($urandom_range(0, 4000)) - 1000;
        rd_delay = 5; wr_delay = 5;
        fork
            job(19'h3000, 19'h6000, 16, 5'd3, 1);
            begin
                repeat (10) @(negedge clk);
                sw_act_rd_addr = 19'h7770; sw_act_wr_addr = 19'h7780; sw_act_len = 16'd3; sw_act_shift = 5'd9;
                sw_act_start = 1;
                @(negedge clk);
                sw_act_start = 0;
            end
        join
        rd_delay = 0; wr_delay = 0;

        job(19'h0, 19'h0, 0, 5'd0, 1);

        acc_mem.delete();
        for (int i = 0; i < 32; i++) acc_mem[(32'h1000 >> 2) + i] = i * 3;
        @(negedge clk);
        n_rd = 0; n_wr = 0;
        sw_act_rd_addr = 19'h1000; sw_act_wr_addr = 19'h6800; sw_act_len = 16'd32; sw_act_shift = 5'd0;
        sw_act_start = 1;
        @(negedge clk);
        sw_act_start = 0;
        cyc = 0;
        while (n_rd < 2 && cyc < 200) begin @(negedge clk); #1; cyc++; end
        check("abort_reach_second_read", n_rd, 2);
        @(negedge clk);
        rst_n = 0;
        bad = 0;
        @(negedge clk);
        check("abort_busy", act_sw_busy_ind, 0);
        check("abort_rd_req", mem_rd_req, 0);
        check("abort_wr_req", mem_wr_req, 0);
        check("abort_wr_be", mem_wr_be, 0);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            bad = bad | act_sw_done | mem_rd_req | mem_wr_req;
        end
        check("abort_quiet", bad, 0);
        check("abort_no_write", n_wr, 0);

        acc_mem.delete();
        for (int i = 0; i < 37; i++) acc_mem[(32'h1800 >> 2) + i] = int'($urandom());
        rd_delay = 1; wr_delay = 2;
        job(19'h1800, 19'h7000, 37, 5'd20, 1);
        rd_delay = 0; wr_delay = 0;
        job(19'h1800, 19'h7400, 32, 5'd24, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
